// File: rtl/rle_pkg.sv
// -----------------------------------------------------------------------------
// rle_pkg
// Shared types and constants for the run-length encoder controller.
//   state_e      : controller FSM states
//   char_cls_e   : classification of an incoming 7-bit code
//   ASCII_MIN/MAX: printable code range, NUL: end-of-string marker
//   is_printable : helper that tests a code against the default printable range
// -----------------------------------------------------------------------------
package rle_pkg;

   typedef enum logic [2:0] {
      IDLE,
      RUN,
      EMIT_CHAR,
      EMIT_CNT,
      ERROR
   } state_e;

   typedef enum logic [1:0] {
      CLS_NUL,
      CLS_PRINT,
      CLS_INVALID
   } char_cls_e;

   localparam logic [6:0] ASCII_MIN = 7'd32;
   localparam logic [6:0] ASCII_MAX = 7'd126;
   localparam logic [6:0] NUL       = 7'h00;

   function automatic logic is_printable(input logic [6:0] c);
      return (c >= ASCII_MIN) && (c <= ASCII_MAX);
   endfunction

endpackage : rle_pkg

// File: rtl/rle_char_class.sv
// -----------------------------------------------------------------------------
// rle_char_class
// Purely combinational classifier of a 7-bit code into exactly one of
// printable, NUL (end of string) or invalid. Shared with the datapath.
//   char_i      : code to classify
//   cls_o       : class as char_cls_e
//   printable_o : LO_CODE <= char_i <= HI_CODE
//   nul_o       : char_i == NUL
//   invalid_o   : neither printable nor NUL
// -----------------------------------------------------------------------------
module rle_char_class
   import rle_pkg::*;
#(
   parameter logic [6:0] LO_CODE = rle_pkg::ASCII_MIN,
   parameter logic [6:0] HI_CODE = rle_pkg::ASCII_MAX
) (
   input  logic [6:0] char_i,
   output char_cls_e  cls_o,
   output logic       printable_o,
   output logic       nul_o,
   output logic       invalid_o
);

   assign nul_o       = (char_i == NUL);
   assign printable_o = (char_i >= LO_CODE) && (char_i <= HI_CODE);
   // NUL wins over the range test so a range that included 0 still ends strings.
   assign invalid_o   = !printable_o && !nul_o;

   always_comb begin
      if (nul_o)            cls_o = CLS_NUL;
      else if (printable_o) cls_o = CLS_PRINT;
      else                  cls_o = CLS_INVALID;
   end

endmodule : rle_char_class

// File: rtl/rle_controller.sv
// -----------------------------------------------------------------------------
// rle_controller
// Sequencing controller of the run-length encoder. Tracks the current run of
// identical printable characters and emits each run as a character byte
// followed by a count byte over a valid/ready stream.
//
// Ports:
//   clock, reset   : rising-edge clock, asynchronous active-high reset
//   in_valid/ready : input handshake, in_data is a 7-bit code (0 = NUL)
//   out_valid/ready: output handshake
//   out_data       : zero-extended character or run count (CNT_W bits)
//   out_is_count   : 1 = out_data carries a count byte
//   busy           : FSM is not IDLE
//   error          : sticky, set by an invalid code, cleared only by reset
//
// Build option RLE_SINGLE_SKIP_EN: when defined, a run of length 1 emits only
// its character byte; the count byte is skipped.
// -----------------------------------------------------------------------------
module rle_controller #(
   parameter int unsigned CNT_W     = 8,
   parameter int unsigned MAX_RUN   = 255,
   parameter logic [6:0]  ASCII_MIN = 7'd32,
   parameter logic [6:0]  ASCII_MAX = 7'd126
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [6:0]       in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [CNT_W-1:0] out_data,
   output logic             out_is_count,
   output logic             busy,
   output logic             error
);

   import rle_pkg::*;

   localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_RUN);
   localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

   state_e           state_q, state_d;
   logic [6:0]       cur_char_q, cur_char_d;
   logic [CNT_W-1:0] run_cnt_q, run_cnt_d;
   logic [6:0]       pend_char_q, pend_char_d;
   logic             pend_valid_q, pend_valid_d;
   logic             eos_q, eos_d;

   char_cls_e        in_cls;
   logic             in_print, in_nul, in_invalid;
   logic             take_exit;

   rle_char_class #(
      .LO_CODE (ASCII_MIN),
      .HI_CODE (ASCII_MAX)
   ) u_char_class (
      .char_i      (in_data),
      .cls_o       (in_cls),
      .printable_o (in_print),
      .nul_o       (in_nul),
      .invalid_o   (in_invalid)
   );

   // NOTE: every signal driven here gets a default first, so no path can
   // leave one unassigned and infer a latch.
   always_comb begin
      state_d      = state_q;
      cur_char_d   = cur_char_q;
      run_cnt_d    = run_cnt_q;
      pend_char_d  = pend_char_q;
      pend_valid_d = pend_valid_q;
      eos_d        = eos_q;
      take_exit    = 1'b0;
      in_ready     = 1'b0;
      out_valid    = 1'b0;
      out_data     = '0;
      out_is_count = 1'b0;

      unique case (state_q)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               if (in_print) begin
                  cur_char_d = in_data;
                  run_cnt_d  = ONE;
                  state_d    = RUN;
               end else if (in_invalid) begin
                  state_d = ERROR;
               end
               // NUL while idle: empty string, nothing to emit.
            end
         end

         RUN: begin
            in_ready = 1'b1;
            if (in_valid) begin
               if (in_invalid) begin
                  state_d = ERROR;
               end else if (in_nul) begin
                  eos_d   = 1'b1;
                  state_d = EMIT_CHAR;
               end else if (in_data == cur_char_q && run_cnt_q < MAX_CNT) begin
                  run_cnt_d = run_cnt_q + ONE;
               end else begin
                  // Either a new character or a saturated run: the beat opens
                  // the next run once the current pair has been emitted.
                  pend_char_d  = in_data;
                  pend_valid_d = 1'b1;
                  state_d      = EMIT_CHAR;
               end
            end
         end

         EMIT_CHAR: begin
            out_valid = 1'b1;
            out_data  = CNT_W'(cur_char_q);
            if (out_ready) begin
`ifdef RLE_SINGLE_SKIP_EN
               if (run_cnt_q == ONE) take_exit = 1'b1;
               else                  state_d   = EMIT_CNT;
`else
               state_d = EMIT_CNT;
`endif
            end
         end

         EMIT_CNT: begin
            out_valid    = 1'b1;
            out_data     = run_cnt_q;
            out_is_count = 1'b1;
            take_exit    = out_ready;
         end

         ERROR: ;

         default: state_d = IDLE;
      endcase

      // Shared end-of-pair actions: either start the pending run or finish.
      if (take_exit) begin
         if (pend_valid_q) begin
            cur_char_d   = pend_char_q;
            run_cnt_d    = ONE;
            pend_valid_d = 1'b0;
            state_d      = RUN;
         end else begin
            eos_d   = 1'b0;
            state_d = IDLE;
         end
      end

      // Keep every output low while reset is held, including IDLE's in_ready.
      if (reset) in_ready = 1'b0;
   end

   // NOTE: state registers use non-blocking assignments so all of them
   // update together from values sampled at the same edge.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q      <= IDLE;
         cur_char_q   <= '0;
         run_cnt_q    <= '0;
         pend_char_q  <= '0;
         pend_valid_q <= 1'b0;
         eos_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         cur_char_q   <= cur_char_d;
         run_cnt_q    <= run_cnt_d;
         pend_char_q  <= pend_char_d;
         pend_valid_q <= pend_valid_d;
         eos_q        <= eos_d;
      end
   end

   assign busy  = (state_q != IDLE);
   assign error = (state_q == ERROR);

endmodule : rle_controller

// File: tb/tb_rle_controller.sv
// -----------------------------------------------------------------------------
// tb_rle_controller
// Self-checking bench for rle_controller. A reference model turns each input
// string into the expected output byte sequence (runs split at MAX_RUN), and
// a monitor records every output handshake for comparison.
// -----------------------------------------------------------------------------
module tb_rle_controller;

   localparam int CNT_W   = 8;
   localparam int MAX_RUN = 255;

   logic             clock = 1'b0;
   logic             reset;
   logic             in_valid;
   logic             in_ready;
   logic [6:0]       in_data;
   logic             out_valid;
   logic             out_ready;
   logic [CNT_W-1:0] out_data;
   logic             out_is_count;
   logic             busy;
   logic             error;

   int   checks  = 0;
   int   errors  = 0;
   logic rand_bp = 1'b0;
   logic aborted = 1'b0;

   // {is_count, data}
   logic [CNT_W:0] got[$];
   logic [CNT_W:0] exp_q[$];
   logic [6:0]     s[$];

   always #5 clock = ~clock;

   rle_controller #(
      .CNT_W   (CNT_W),
      .MAX_RUN (MAX_RUN)
   ) dut (
      .clock        (clock),
      .reset        (reset),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_data      (in_data),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_data     (out_data),
      .out_is_count (out_is_count),
      .busy         (busy),
      .error        (error)
   );

   // Inputs change 1 time unit after posedge, so the negedge view equals the
   // values the DUT sees at the following posedge.
   always @(negedge clock)
      if (!reset && out_valid && out_ready)
         got.push_back({out_is_count, out_data});

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, expv);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
      if (rand_bp) out_ready = ($urandom_range(0, 3) != 0);
   endtask

   // ---------------- reference model ----------------
   task automatic emit_run(input logic [6:0] c, input int n);
      int left = n;
      while (left > 0) begin
         int chunk = (left > MAX_RUN) ? MAX_RUN : left;
         exp_q.push_back({1'b0, 8'(c)});
`ifdef RLE_SINGLE_SKIP_EN
         if (chunk != 1)
`endif
         exp_q.push_back({1'b1, 8'(chunk)});
         left -= chunk;
      end
   endtask

   task automatic build_expected(input logic [6:0] str[$]);
      logic [6:0] ch   = '0;
      int         n    = 0;
      exp_q.delete();
      foreach (str[i]) begin
         logic [6:0] c = str[i];
         if (c == 7'h00) begin
            if (n > 0) emit_run(ch, n);
            break;
         end else if (c < 7'd32 || c > 7'd126) begin
            break;  // invalid: current run is dropped
         end else if (n > 0 && c == ch) begin
            n++;
         end else begin
            if (n > 0) emit_run(ch, n);
            ch = c;
            n  = 1;
         end
      end
   endtask

   // ---------------- drivers ----------------
   task automatic send_beat(input logic [6:0] c);
      logic acc = 1'b0;
      if (aborted) return;
      in_valid = 1'b1;
      in_data  = c;
      for (int k = 0; k < 4000 && !acc; k++) begin
         if (in_ready) acc = 1'b1;
         step();
      end
      in_valid = 1'b0;
      if (!acc) begin
         check("beat_accept_timeout", 32'(acc), 32'd1);
         aborted = 1'b1;
      end
   endtask

   task automatic send_string(input logic [6:0] str[$]);
      foreach (str[i]) send_beat(str[i]);
   endtask

   task automatic wait_idle(input string tag);
      for (int k = 0; k < 20000 && busy; k++) step();
      check(tag, 32'(busy), 32'd0);
   endtask

   task automatic compare(input string tag);
      int n = (got.size() < exp_q.size()) ? got.size() : exp_q.size();
      check({tag, "_len"}, got.size(), exp_q.size());
      for (int i = 0; i < n; i++)
         check($sformatf("%s[%0d]", tag, i), 32'(got[i]), 32'(exp_q[i]));
      got.delete();
   endtask

   task automatic do_reset();
      in_valid = 1'b0;
      reset    = 1'b1;
      step();
      step();
      reset   = 1'b0;
      aborted = 1'b0;
      step();
      got.delete();
   endtask

   // ---------------- stimulus ----------------
   initial begin
      reset     = 1'b1;
      in_valid  = 1'b0;
      in_data   = '0;
      out_ready = 1'b0;
      #2;
      check("rst_in_ready",     32'(in_ready),     32'd0);
      check("rst_out_valid",    32'(out_valid),    32'd0);
      check("rst_out_data",     32'(out_data),     32'd0);
      check("rst_out_is_count", 32'(out_is_count), 32'd0);
      check("rst_busy",         32'(busy),         32'd0);
      check("rst_error",        32'(error),        32'd0);
      do_reset();
      check("idle_in_ready", 32'(in_ready), 32'd1);

      // "AAAB" NUL with no back-pressure
      out_ready = 1'b1;
      s = '{7'h41, 7'h41, 7'h41, 7'h42, 7'h00};
      build_expected(s);
      send_string(s);
      wait_idle("aaab_idle");
      compare("aaab");

      // 300 x 'Z' NUL: run splits at MAX_RUN
      s.delete();
      repeat (300) s.push_back(7'h5A);
      s.push_back(7'h00);
      build_expected(s);
      send_string(s);
      wait_idle("zrun_idle");
      compare("zrun");

      // "AB" with the character byte stalled for 5 cycles
      out_ready = 1'b0;
      s = '{7'h41, 7'h42, 7'h00};
      build_expected(s);
      send_beat(7'h41);
      send_beat(7'h42);
      in_valid = 1'b1;
      in_data  = 7'h00;
      for (int k = 0; k < 5; k++) begin
         check("stall_out_valid", 32'(out_valid),    32'd1);
         check("stall_out_data",  32'(out_data),     32'h41);
         check("stall_is_count",  32'(out_is_count), 32'd0);
         check("stall_in_ready",  32'(in_ready),     32'd0);
         step();
      end
      out_ready = 1'b1;
      send_beat(7'h00);
      wait_idle("stall_idle");
      compare("stall");

      // "MM" then invalid 0x1F: sticky error, run discarded
      s = '{7'h4D, 7'h4D, 7'h1F};
      build_expected(s);
      send_string(s);
      check("err_flag",      32'(error),     32'd1);
      check("err_in_ready",  32'(in_ready),  32'd0);
      check("err_out_valid", 32'(out_valid), 32'd0);
      repeat (5) step();
      check("err_hold_flag",     32'(error),    32'd1);
      check("err_hold_in_ready", 32'(in_ready), 32'd0);
      compare("err");
      do_reset();
      check("err_cleared", 32'(error), 32'd0);

      // Reset while the count byte is being presented
      out_ready = 1'b0;
      send_string('{7'h51, 7'h51, 7'h00});
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      check("cnt_is_count", 32'(out_is_count), 32'd1);
      check("cnt_data",     32'(out_data),     32'd2);
      #2 reset = 1'b1;
      #1;
      check("async_rst_out_valid", 32'(out_valid), 32'd0);
      check("async_rst_busy",      32'(busy),      32'd0);
      step();
      reset = 1'b0;
      step();
      got.delete();
      out_ready = 1'b1;
      s = '{7'h51, 7'h51, 7'h00};
      build_expected(s);
      send_string(s);
      wait_idle("qq_idle");
      compare("qq");

      // Random strings with random back-pressure
      rand_bp = 1'b1;
      for (int t = 0; t < 6; t++) begin
         int nruns = $urandom_range(1, 12);
         s.delete();
         for (int r = 0; r < nruns; r++) begin
            logic [6:0] c = 7'($urandom_range(65, 68));
            int n = ($urandom_range(0, 9) == 0) ? $urandom_range(250, 270)
                                                : $urandom_range(1, 5);
            repeat (n) s.push_back(c);
         end
         s.push_back(7'h00);
         build_expected(s);
         send_string(s);
         wait_idle($sformatf("rnd%0d_idle", t));
         compare($sformatf("rnd%0d", t));
      end
      rand_bp   = 1'b0;
      out_ready = 1'b1;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_rle_controller

// File: doc/rle_controller.md
Name: rle_controller

Overview:
- Sequencing controller for the run-length encoder datapath.
- Accepts a 7-bit ASCII character stream over a valid/ready handshake and tracks the current run of identical characters.
- Emits each run as a character byte followed by a count byte on a valid/ready output stream.
- Handles end-of-string (NUL), the maximum run length, invalid-character errors and downstream back-pressure.

Parameters:
- CNT_W, 8, width of the run counter and of out_data.
- MAX_RUN, 255, longest run emitted as one pair; must be at most 2^CNT_W-1.
- ASCII_MIN, 32, lowest printable code accepted.
- ASCII_MAX, 126, highest printable code accepted.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  in_data is valid this cycle.
- in_ready  out  1  controller accepts a beat this cycle.
- in_data  in  7  ASCII character; 0 = NUL = end of string.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  downstream accepts out_data.
- out_data  out  CNT_W  character (zero-extended) or run count.
- out_is_count  out  1  1 = out_data is a count byte, 0 = character byte.
- busy  out  1  high in any state other than IDLE.
- error  out  1  sticky invalid-input flag.

Behaviour:
- Reset values: all outputs 0. State = IDLE, cur_char = 0, run_cnt = 0, pend_valid = 0, eos_flag = 0.
- Clock and reset are fixed: one clock, reset asynchronous and active-high. A mid-operation reset drops any run and pending character and clears out_valid immediately.
- Beat acceptance: a beat is accepted when in_valid && in_ready. A beat is printable when ASCII_MIN <= in_data <= ASCII_MAX. Any non-NUL code outside that range is invalid.
- State IDLE (in_ready = 1):
  - Printable beat: cur_char <= in_data, run_cnt <= 1, go to RUN.
  - NUL: ignored; an empty string produces no output.
  - Invalid beat: go to ERROR.
- State RUN (in_ready = 1):
  - Same character and run_cnt < MAX_RUN: run_cnt++.
  - Same character and run_cnt == MAX_RUN: pend_char <= in_data, pend_valid <= 1, go to EMIT_CHAR.
  - Different printable character: pend_char <= in_data, pend_valid <= 1, go to EMIT_CHAR.
  - NUL: eos_flag <= 1, go to EMIT_CHAR.
  - Invalid beat: go to ERROR; the current run is discarded and never emitted.
- State EMIT_CHAR (in_ready = 0):
  - out_valid = 1, out_data = cur_char zero-extended, out_is_count = 0.
  - On out_ready, go to EMIT_CNT.
- State EMIT_CNT (in_ready = 0):
  - out_valid = 1, out_data = run_cnt (range 1..MAX_RUN), out_is_count = 1.
  - On out_ready with pend_valid: cur_char <= pend_char, run_cnt <= 1, pend_valid <= 0, go to RUN.
  - On out_ready with eos_flag: eos_flag <= 0, go to IDLE.
- State ERROR: error = 1, in_ready = 0, out_valid = 0. Left only by reset.
- Output stability: out_data and out_is_count are held stable while out_valid && !out_ready. out_valid never drops without a handshake, except on reset.
- Latency: the character byte of a run is presented the cycle after the terminating beat is accepted. The count byte follows the cycle after the character handshake. Minimum 2 cycles per pair with out_ready held high.
- Arithmetic: run_cnt never exceeds MAX_RUN and never wraps. Counts are run lengths, not repeat counts, so a single character gives count 1.

Optional Feature:
- Macro: RLE_SINGLE_SKIP_EN.
- Defined: a run of length 1 emits only its character byte. EMIT_CHAR proceeds directly to the EMIT_CNT exit actions (pending load or IDLE) when run_cnt == 1. Downstream decodes with out_is_count.
- Undefined: every run emits both bytes.

Decomposition:
- Package rle_pkg:
  - State enum: IDLE, RUN, EMIT_CHAR, EMIT_CNT, ERROR.
  - Constants: ASCII_MIN, ASCII_MAX, NUL = 7'h00.
  - Function is_printable(logic [6:0]).
- Sub-module rle_char_class: combinational classifier of in_data into printable, NUL or invalid. It is reused by the datapath.
- FSM, counter and pending register stay in rle_controller.

Test Plan:
- "AAAB" then NUL, out_ready = 1 -> out bytes 0x41/c0, 0x03/c1, 0x42/c0, 0x01/c1; then busy = 0 and state IDLE.
- 300 x 'Z' then NUL, MAX_RUN = 255 -> 0x5A, 0xFF, 0x5A, 0x2D; run_cnt never exceeds 255.
- "AB", out_ready low for 5 cycles during EMIT_CHAR -> out_data held at 0x41, in_ready = 0, 'B' not lost; then 0x41, 0x01, 0x42, 0x01.
- "MM", then 0x1F -> error = 1 next cycle, no output bytes, in_ready = 0 until reset.
- Reset asserted during EMIT_CNT -> out_valid = 0 asynchronously, state IDLE. Then "QQ" NUL -> 0x51, 0x02.
- Build with RLE_SINGLE_SKIP_EN: "AB" NUL -> 0x41/c0, 0x42/c0 only; "AA" NUL -> 0x41/c0, 0x02/c1.
